// File: rtl/kronos_pkg.sv
// Shared types and constants for the Kronos Keccak operation scheduler.
package kronos_pkg;

    localparam int KECCAK_ROUNDS  = 24;
    localparam int SCHED_ID_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PERM   = 2'd1,
        STORE  = 2'd2,
        RESULT = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [SCHED_ID_WIDTH-1:0] id;
        logic                      store;
        logic                      committed;
        logic                      killed;
    } sched_entry_t;

    // An entry can still be claimed by a commit only while it is undecided.
    function automatic logic entry_open(input sched_entry_t e);
        return (e.committed == 1'b0) && (e.killed == 1'b0);
    endfunction

endpackage

// File: rtl/kronos_keccak_sched_if.sv
// Request, commit, datapath-control and result signals of the Keccak scheduler.
interface kronos_keccak_sched_if #(
    parameter int ID_WIDTH = 4,
    parameter int DEPTH    = 4
);
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [ID_WIDTH-1:0]     req_id_i;
    logic                    req_store_i;
    logic                    commit_valid_i;
    logic [ID_WIDTH-1:0]     commit_id_i;
    logic                    commit_kill_i;
    logic                    round_valid_o;
    logic [4:0]              round_o;
    logic                    store_o;
    logic                    keccak_done_o;
    logic                    result_valid_o;
    logic                    result_ready_i;
    logic [ID_WIDTH-1:0]     result_id_o;
    logic                    result_store_o;
    logic                    busy_o;
    logic [$clog2(DEPTH):0]  count_o;

    modport master (
        output req_valid_i, req_id_i, req_store_i,
        output commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
        input  req_ready_o, round_valid_o, round_o, store_o, keccak_done_o,
        input  result_valid_o, result_id_o, result_store_o, busy_o, count_o
    );

    modport slave (
        input  req_valid_i, req_id_i, req_store_i,
        input  commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
        output req_ready_o, round_valid_o, round_o, store_o, keccak_done_o,
        output result_valid_o, result_id_o, result_store_o, busy_o, count_o
    );
endinterface

// File: rtl/kronos_sched_queue.sv
// In-order pending-operation queue with commit/kill marking of the oldest
// undecided entry carrying the committed id.
module kronos_sched_queue
    import kronos_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enq_valid_i,
    input  logic [SCHED_ID_WIDTH-1:0] enq_id_i,
    input  logic                      enq_store_i,
    input  logic                      commit_valid_i,
    input  logic [SCHED_ID_WIDTH-1:0] commit_id_i,
    input  logic                      commit_kill_i,
    input  logic                      deq_i,
    output sched_entry_t              head_o,
    output logic                      ready_o,
    output logic [$clog2(DEPTH):0]    count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W:0] cnt_t;
    localparam cnt_t FULL_COUNT = cnt_t'(DEPTH);

    sched_entry_t     entries_r [DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic [PTR_W:0]   count_s;
    logic             enq_fire_s;
    logic             match_found_s;
    logic [PTR_W-1:0] match_idx_s;
    logic             new_match_s;

    assign count_s    = wr_ptr_r - rd_ptr_r;
    assign ready_o    = (count_s < FULL_COUNT);
    assign count_o    = count_s;
    assign enq_fire_s = enq_valid_i && ready_o;
    assign head_o     = entries_r[rd_ptr_r[PTR_W-1:0]];
    // A commit missing every queued entry may claim the entry written this cycle.
    assign new_match_s = commit_valid_i && !match_found_s && enq_fire_s &&
                         (enq_id_i == commit_id_i);

    // Scan from the head towards the tail for the oldest undecided matching entry.
    always_comb begin
        logic [PTR_W-1:0] idx_v;
        match_found_s = 1'b0;
        match_idx_s   = '0;
        idx_v         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_v = rd_ptr_r[PTR_W-1:0] + PTR_W'(i);
            if (!match_found_s && (cnt_t'(i) < count_s) && commit_valid_i &&
                (entries_r[idx_v].id == commit_id_i) && entry_open(entries_r[idx_v])) begin
                match_found_s = 1'b1;
                match_idx_s   = idx_v;
            end else begin
                match_idx_s   = match_idx_s;
            end
        end
    end

    // Pointer update, entry write and commit/kill marking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
        end else begin
            if (enq_fire_s) begin
                entries_r[wr_ptr_r[PTR_W-1:0]] <= '{id:        enq_id_i,
                                                    store:     enq_store_i,
                                                    committed: new_match_s && !commit_kill_i,
                                                    killed:    new_match_s && commit_kill_i};
                wr_ptr_r <= wr_ptr_r + cnt_t'(1);
            end
            // The matched slot is always occupied, so it never collides with the write slot.
            if (match_found_s) begin
                entries_r[match_idx_s].committed <= !commit_kill_i;
                entries_r[match_idx_s].killed    <= commit_kill_i;
            end
            if (deq_i) begin
                rd_ptr_r <= rd_ptr_r + cnt_t'(1);
            end
        end
    end

endmodule

// File: rtl/kronos_keccak_sched.sv
// Keccak operation scheduler: queues tagged operations, waits for their
// commit/kill decision and then drives the datapath one operation at a time.
module kronos_keccak_sched
    import kronos_pkg::*;
#(
    parameter int NUM_ROUNDS = KECCAK_ROUNDS,
    parameter int ID_WIDTH   = SCHED_ID_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    kronos_keccak_sched_if.slave  bus
);
    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);

    sched_state_t           state_r;
    sched_state_t           state_next_s;
    logic [4:0]             round_r;
    logic [ID_WIDTH-1:0]    work_id_r;
    logic                   work_store_r;
    sched_entry_t           head_s;
    logic                   ready_s;
    logic [$clog2(DEPTH):0] count_s;
    logic                   deq_s;
    logic                   load_s;
    logic                   queue_empty_s;

    assign queue_empty_s = (count_s == '0);

    kronos_sched_queue #(.DEPTH(DEPTH)) u_queue (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .enq_valid_i    (bus.req_valid_i),
        .enq_id_i       (bus.req_id_i),
        .enq_store_i    (bus.req_store_i),
        .commit_valid_i (bus.commit_valid_i),
        .commit_id_i    (bus.commit_id_i),
        .commit_kill_i  (bus.commit_kill_i),
        .deq_i          (deq_s),
        .head_o         (head_s),
        .ready_o        (ready_s),
        .count_o        (count_s)
    );

    // Next-state decode: killed heads are dropped, committed heads are started.
    always_comb begin
        state_next_s = state_r;
        deq_s        = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (!queue_empty_s && head_s.killed) begin
                    deq_s = 1'b1;
                end else if (!queue_empty_s && head_s.committed) begin
                    deq_s        = 1'b1;
                    load_s       = 1'b1;
                    state_next_s = head_s.store ? STORE : PERM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PERM: begin
                if (round_r == LAST_ROUND) begin
                    state_next_s = RESULT;
                end else begin
                    state_next_s = PERM;
                end
            end
            STORE:  state_next_s = RESULT;
            RESULT: begin
                if (bus.result_ready_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESULT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Round counter and working register of the operation in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            round_r      <= 5'd0;
            work_id_r    <= '0;
            work_store_r <= 1'b0;
        end else if (load_s) begin
            round_r      <= 5'd0;
            work_id_r    <= head_s.id;
            work_store_r <= head_s.store;
        end else if (state_r == PERM && round_r != LAST_ROUND) begin
            round_r <= round_r + 5'd1;
        end else begin
            round_r <= 5'd0;
        end
    end

    assign bus.req_ready_o    = ready_s;
    assign bus.round_valid_o  = (state_r == PERM);
    assign bus.round_o        = (state_r == PERM) ? round_r : 5'd0;
    assign bus.keccak_done_o  = (state_r == PERM) && (round_r == LAST_ROUND);
    assign bus.store_o        = (state_r == STORE);
    assign bus.result_valid_o = (state_r == RESULT);
    assign bus.result_id_o    = (state_r == RESULT) ? work_id_r : '0;
    assign bus.result_store_o = (state_r == RESULT) && work_store_r;
    assign bus.busy_o         = !queue_empty_s || (state_r != IDLE);
    assign bus.count_o        = count_s;

endmodule

// File: tb/tb_kronos_keccak_sched.sv
// Directed and randomized bench for kronos_keccak_sched against a queue-level
// reference model of pending operations and the documented cycle timing.
module tb_kronos_keccak_sched;
    localparam int NR    = 24;
    localparam int IDW   = 4;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kronos_keccak_sched_if #(.ID_WIDTH(IDW), .DEPTH(DEPTH)) bus ();

    kronos_keccak_sched #(.NUM_ROUNDS(NR), .ID_WIDTH(IDW), .DEPTH(DEPTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [3:0] id;
        logic       st;
        logic       com;
        logic       kil;
    } m_ent_t;

    m_ent_t pend_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Oldest undecided entry with this id takes the decision; otherwise ignored.
    function automatic void model_commit(input logic [3:0] id, input logic kill);
        for (int i = 0; i < pend_q.size(); i++) begin
            if (pend_q[i].id == id && !pend_q[i].com && !pend_q[i].kil) begin
                if (kill) pend_q[i].kil = 1'b1;
                else      pend_q[i].com = 1'b1;
                break;
            end
        end
    endfunction

    task automatic drive_idle();
        bus.req_valid_i    = 1'b0;
        bus.req_id_i       = 4'd0;
        bus.req_store_i    = 1'b0;
        bus.commit_valid_i = 1'b0;
        bus.commit_id_i    = 4'd0;
        bus.commit_kill_i  = 1'b0;
        bus.result_ready_i = 1'b0;
    endtask

    task automatic cycle(input logic rv, input logic [3:0] rid, input logic rst,
                         input logic cv, input logic [3:0] cid, input logic ck);
        bus.req_valid_i    = rv;
        bus.req_id_i       = rid;
        bus.req_store_i    = rst;
        bus.commit_valid_i = cv;
        bus.commit_id_i    = cid;
        bus.commit_kill_i  = ck;
        if (rv) chk("req_ready", bus.req_ready_o, pend_q.size() < DEPTH);
        if (rv && pend_q.size() < DEPTH) pend_q.push_back('{rid, rst, 1'b0, 1'b0});
        if (cv) model_commit(cid, ck);
        tick();
        drive_idle();
    endtask

    task automatic quiet(input string tag);
        chk({tag, "_round_valid"}, bus.round_valid_o, 1'b0);
        chk({tag, "_store"}, bus.store_o, 1'b0);
        chk({tag, "_done"}, bus.keccak_done_o, 1'b0);
        chk({tag, "_result_valid"}, bus.result_valid_o, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready_o, 1'b1);
        quiet(tag);
        chk({tag, "_round"}, bus.round_o, 5'd0);
        chk({tag, "_result_id"}, bus.result_id_o, 4'd0);
        chk({tag, "_result_store"}, bus.result_store_o, 1'b0);
        chk({tag, "_busy"}, bus.busy_o, 1'b0);
        chk({tag, "_count"}, bus.count_o, 3'd0);
    endtask

    // Called in the cycle where the committed head is sitting at IDLE.
    task automatic run_op(input int hold);
        m_ent_t e;
        chk("start_count", bus.count_o, pend_q.size());
        quiet("start");
        e = pend_q.pop_front();
        if (!e.st) begin
            for (int r = 0; r < NR; r++) begin
                tick();
                chk("perm_round_valid", bus.round_valid_o, 1'b1);
                chk("perm_round", bus.round_o, r);
                chk("perm_done", bus.keccak_done_o, r == NR - 1);
                chk("perm_no_result", bus.result_valid_o, 1'b0);
            end
        end else begin
            tick();
            chk("store_strobe", bus.store_o, 1'b1);
            chk("store_no_round", bus.round_valid_o, 1'b0);
            chk("store_no_result", bus.result_valid_o, 1'b0);
        end
        tick();
        for (int h = 0; h <= hold; h++) begin
            chk("result_valid", bus.result_valid_o, 1'b1);
            chk("result_id", bus.result_id_o, e.id);
            chk("result_store", bus.result_store_o, e.st);
            chk("hold_no_round", bus.round_valid_o, 1'b0);
            chk("hold_no_store", bus.store_o, 1'b0);
            if (h < hold) tick();
        end
        bus.result_ready_i = 1'b1;
        tick();
        bus.result_ready_i = 1'b0;
        chk("after_handshake_valid", bus.result_valid_o, 1'b0);
        chk("after_handshake_busy", bus.busy_o, pend_q.size() != 0);
    endtask

    // Retire every decided head; stops at an undecided head or an empty queue.
    task automatic service(input int hold);
        int guard = 0;
        while (pend_q.size() > 0 && guard < 16) begin
            guard++;
            if (pend_q[0].kil) begin
                chk("kill_count", bus.count_o, pend_q.size());
                quiet("kill");
                void'(pend_q.pop_front());
                tick();
            end else if (pend_q[0].com) begin
                run_op(hold);
            end else begin
                break;
            end
        end
    endtask

    initial begin
        logic [3:0] ids [4];
        logic [3:0] base;
        int         n;

        drive_idle();
        #1;
        check_reset("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_reset("post_reset");

        // Single permute: enqueue id 3, commit one cycle later.
        cycle(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("uncommitted_count", bus.count_o, 3'd1);
        chk("uncommitted_busy", bus.busy_o, 1'b1);
        quiet("uncommitted");
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0);
        service(2);

        // Store op enqueued and committed in the same cycle.
        cycle(1'b1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b0);
        service(0);

        // Kill id 1, commit id 2: only id 2 returns.
        cycle(1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0);
        cycle(1'b1, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b1);
        service(1);
        for (int k = 0; k < 4; k++) begin
            quiet("after_kill");
            tick();
        end

        // Full queue, rejected fifth request, unmatched commit, in-order results.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 4'(k), 1'($urandom % 2), 1'b0, 4'd0, 1'b0);
        end
        chk("full_ready", bus.req_ready_o, 1'b0);
        chk("full_count", bus.count_o, 3'd4);
        cycle(1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("fifth_rejected_count", bus.count_o, 3'd4);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0);
        quiet("unmatched_commit");
        for (int k = 3; k >= 0; k--) begin
            cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'(k), 1'b0);
        end
        service($urandom_range(0, 3));

        // Duplicate id: the commit must land on the oldest entry.
        cycle(1'b1, 4'd6, 1'b0, 1'b0, 4'd0, 1'b0);
        cycle(1'b1, 4'd6, 1'b1, 1'b0, 4'd0, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0);
        service(0);
        chk("dup_wait_count", bus.count_o, 3'd1);
        quiet("dup_wait");
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0);
        service(0);

        // Backpressure for 10 cycles with a committed op waiting behind.
        cycle(1'b1, 4'd8, 1'b0, 1'b0, 4'd0, 1'b0);
        cycle(1'b1, 4'd9, 1'($urandom % 2), 1'b0, 4'd0, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'd8, 1'b0);
        service(10);

        // Randomized batches with random stores, kills and backpressure.
        repeat (6) begin
            n    = $urandom_range(1, 4);
            base = 4'($urandom % 16);
            for (int k = 0; k < n; k++) begin
                ids[k] = base + 4'(3 * k);
                cycle(1'b1, ids[k], 1'($urandom % 2), 1'b0, 4'd0, 1'b0);
            end
            for (int k = n - 1; k >= 0; k--) begin
                cycle(1'b0, 4'd0, 1'b0, 1'b1, ids[k], ($urandom % 4) == 0);
            end
            service($urandom_range(0, 3));
            chk("batch_empty_busy", bus.busy_o, 1'b0);
        end

        // Reset in the middle of a permutation.
        cycle(1'b1, 4'd10, 1'b0, 1'b1, 4'd10, 1'b0);
        quiet("pre_reset_op");
        void'(pend_q.pop_front());
        repeat (11) tick();
        chk("mid_round_valid", bus.round_valid_o, 1'b1);
        chk("mid_round", bus.round_o, 5'd10);
        rst_n = 1'b0;
        #1;
        check_reset("mid_reset");
        pend_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            chk("post_reset_no_result", bus.result_valid_o, 1'b0);
            chk("post_reset_no_round", bus.round_valid_o, 1'b0);
        end
        chk("post_reset_count", bus.count_o, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kronos_keccak_sched.md
# kronos_keccak_sched

In-order scheduler between the core-side X-interface controller and the Kronos Keccak datapath. It queues offloaded Keccak operations tagged with their X-interface id and holds each one until it is committed or killed. It then drives the datapath one round per cycle (permute) or for one read-out cycle (store), and returns a tagged result through a valid/ready handshake. Only one operation occupies the datapath at a time.

## Interface
- NUM_ROUNDS, 24, Keccak-f rounds per permutation
- ID_WIDTH, 4, X-interface instruction id width
- DEPTH, 4, pending-operation queue entries (power of two, ≥2)
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- req_valid_i  in  1  new operation offered
- req_ready_o  out  1  queue can accept
- req_id_i  in  ID_WIDTH  id of offered operation
- req_store_i  in  1  1 = store/read-out op, 0 = permutation
- commit_valid_i  in  1  commit event
- commit_id_i  in  ID_WIDTH  id being committed
- commit_kill_i  in  1  1 = discard the operation, 0 = execute it
- round_valid_o  out  1  datapath applies one round this cycle
- round_o  out  5  round index 0..NUM_ROUNDS-1
- store_o  out  1  datapath state read-out strobe
- keccak_done_o  out  1  one-cycle pulse when a permutation completes
- result_valid_o  out  1  result available
- result_ready_i  in  1  consumer accepts result
- result_id_o  out  ID_WIDTH  id of the returned operation
- result_store_o  out  1  returned operation was a store
- busy_o  out  1  queue non-empty or FSM not IDLE
- count_o  out  $clog2(DEPTH)+1  queued entries

## Operation
- Queue entry = {id, store, committed, killed}. Enqueue occurs when req_valid_i && req_ready_o. req_ready_o = (count < DEPTH); it is independent of a same-cycle dequeue.
- Commit matching: the oldest valid entry with a matching id and committed=killed=0 is marked. A commit that matches no entry is ignored. A commit whose id equals req_id_i during the enqueue cycle applies to the new entry, provided no older entry matches.
- FSM states: IDLE, PERM, STORE, RESULT.
- IDLE, head killed: pop the head; stay in IDLE; produce no datapath activity and no result.
- IDLE, head committed: pop the head into a working register {id, store}. If store=1, go to STORE; otherwise go to PERM with round counter = 0.
- IDLE, head uncommitted or queue empty: wait.
- PERM: round_valid_o=1 and round_o=counter each cycle. At counter = NUM_ROUNDS-1, go to RESULT and pulse keccak_done_o on that same last-round cycle. Otherwise counter increments.
- STORE: store_o=1 for exactly one cycle, then go to RESULT.
- RESULT: result_valid_o=1 with result_id_o/result_store_o taken from the working register. These are held stable until result_ready_i; on the handshake, go to IDLE.
- Enqueue, commit marking and dequeue can all occur in the same cycle without conflict. Count is updated by +1, -1 or 0 accordingly.
- Reset, including mid-operation: queue emptied, FSM to IDLE, counter 0. The in-flight operation is dropped and no result is produced.

## Timing
- Reset values: req_ready_o=1; every other output 0.
- Committed head at IDLE in cycle T: round 0 at T+1, round NUM_ROUNDS-1 with keccak_done_o at T+NUM_ROUNDS, result_valid_o from T+NUM_ROUNDS+1.
- Store op: store_o at T+1, result_valid_o from T+2.
- A commit registered in cycle C makes the entry eligible in C+1.
- Back-to-back operations: after a result handshake at cycle R, the FSM is in IDLE at R+1 and the next op starts at R+2.
- Killed head costs one IDLE cycle per entry.
- All outputs are registered or decoded from FSM state only; there is no combinational path from any input to any output.

## Structure
- kronos_pkg gains: sched_state_t (IDLE/PERM/STORE/RESULT), sched_entry_t struct, constant KECCAK_ROUNDS=24.
- Sub-module kronos_sched_queue is a DEPTH-entry circular buffer with read/write pointers carrying one extra wrap bit, per-entry commit/kill marking, and an oldest-match search.
- The FSM and round counter live in kronos_keccak_sched.

## Test plan
- Single permute: enqueue id 3; commit id 3 (kill=0) one cycle later → round_o 0..23 on consecutive cycles, keccak_done_o with round 23, then result_valid_o with result_id_o=3, result_store_o=0.
- Store op: enqueue id 5 with store=1 and commit it in the same cycle → store_o high one cycle, then result id 5, result_store_o=1.
- Kill: enqueue ids 1 and 2; kill 1, commit 2 → no rounds for id 1; id 2 permutes and returns; exactly one result.
- Full queue: enqueue 4 ops with no commit → req_ready_o=0, count_o=4, a fifth req_valid_i is not accepted. Commit all four → four results returned in order 0..3.
- Backpressure: hold result_ready_i=0 for 10 cycles → result_valid_o and result_id_o stay stable and the next committed op does not start.
- Reset at round 10: assert rst_ni low → all outputs return to reset values immediately; count_o=0 and no result after release.
